// File: rtl/answer_record.sv
// Answer-phase controller: takes the detector's latched winner, times the answer window,
// applies host judgement to four saturating scores, then releases the detector latch.
module answer_record #(
   parameter  int unsigned ANSWER_TIME = 10,
   parameter  int unsigned SCORE_W     = 4,
   localparam int unsigned TW          = $clog2(ANSWER_TIME + 1)
) (
   input  logic               clk_count,
   input  logic               rst,
   input  logic               en_s0,
   input  logic               en_s1,
   input  logic               en_s2,
   input  logic               en_s3,
   input  logic               tick,
   input  logic               ok,
   input  logic               ng,
   input  logic               clr_score,
   output logic               count,
   output logic               zd_r,
   output logic [1:0]         winner,
   output logic               winner_vld,
   output logic [TW-1:0]      timer,
   output logic [SCORE_W-1:0] score0,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic [SCORE_W-1:0] score3,
   output logic               timeout,
   output logic               err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ANSWER = 2'd1,
      CLEAR  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic                 count_q, count_d;
   logic                 zd_r_q, zd_r_d;
   logic [1:0]           winner_q, winner_d;
   logic                 winner_vld_q, winner_vld_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic                 timeout_q, timeout_d;
   logic                 err_q, err_d;
   logic [SCORE_W-1:0]   score_q [4];
   logic [SCORE_W-1:0]   score_d [4];

   logic [3:0]           en;
   logic                 one_hot;
   logic                 multi;
   logic [1:0]           en_idx;
   logic                 ok_only;
   logic                 ng_only;
   logic                 expire;

   assign en = {en_s3, en_s2, en_s1, en_s0};

   always_comb begin
      one_hot = 1'b0;
      multi   = 1'b0;
      en_idx  = 2'd0;
      case (en)
         4'b0000: ;
         4'b0001: begin one_hot = 1'b1; en_idx = 2'd0; end
         4'b0010: begin one_hot = 1'b1; en_idx = 2'd1; end
         4'b0100: begin one_hot = 1'b1; en_idx = 2'd2; end
         4'b1000: begin one_hot = 1'b1; en_idx = 2'd3; end
         default: multi = 1'b1;
      endcase
   end

   // ok together with ng cancels both, and any judgement masks a same-cycle tick
   assign ok_only = ok & ~ng;
   assign ng_only = ng & ~ok;
   assign expire  = ~ok & ~ng & tick & (timer_q == TW'(1));

   always_ff @(posedge clk_count) begin
      if (rst) begin
         state_q      <= IDLE;
         count_q      <= 1'b0;
         zd_r_q       <= 1'b0;
         winner_q     <= 2'd0;
         winner_vld_q <= 1'b0;
         timer_q      <= '0;
         timeout_q    <= 1'b0;
         err_q        <= 1'b0;
         for (int unsigned i = 0; i < 4; i++) score_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         zd_r_q       <= zd_r_d;
         winner_q     <= winner_d;
         winner_vld_q <= winner_vld_d;
         timer_q      <= timer_d;
         timeout_q    <= timeout_d;
         err_q        <= err_d;
         for (int unsigned i = 0; i < 4; i++) score_q[i] <= score_d[i];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (one_hot)    state_d = ANSWER;
            else if (multi) state_d = CLEAR;
         end
         ANSWER: begin
            if (ok_only || ng_only || expire) state_d = CLEAR;
         end
         CLEAR: begin
            if (en == 4'b0000) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      count_d      = count_q;
      zd_r_d       = zd_r_q;
      winner_d     = winner_q;
      winner_vld_d = winner_vld_q;
      timer_d      = timer_q;
      timeout_d    = 1'b0;
      err_d        = 1'b0;
      for (int unsigned i = 0; i < 4; i++) score_d[i] = score_q[i];

      case (state_q)
         IDLE: begin
            if (one_hot) begin
               winner_d     = en_idx;
               winner_vld_d = 1'b1;
               count_d      = 1'b1;
               timer_d      = TW'(ANSWER_TIME);
            end else if (multi) begin
               err_d   = 1'b1;
               count_d = 1'b1;
               zd_r_d  = 1'b1;
            end
         end
         ANSWER: begin
            if (ok_only) begin
               if (score_q[winner_q] != '1)
                  score_d[winner_q] = score_q[winner_q] + SCORE_W'(1);
               zd_r_d = 1'b1;
            end else if (ng_only || expire) begin
               if (score_q[winner_q] != '0)
                  score_d[winner_q] = score_q[winner_q] - SCORE_W'(1);
               zd_r_d = 1'b1;
               if (expire) begin
                  timer_d   = '0;
                  timeout_d = 1'b1;
               end
            end else if (!ok && !ng && tick && timer_q > TW'(1)) begin
               timer_d = timer_q - TW'(1);
            end
         end
         CLEAR: begin
            if (en == 4'b0000) begin
               zd_r_d       = 1'b0;
               count_d      = 1'b0;
               winner_vld_d = 1'b0;
               timer_d      = '0;
            end
         end
         default: ;
      endcase

      if (clr_score) begin
         for (int unsigned i = 0; i < 4; i++) score_d[i] = '0;
      end
   end

   assign count      = count_q;
   assign zd_r       = zd_r_q;
   assign winner     = winner_q;
   assign winner_vld = winner_vld_q;
   assign timer      = timer_q;
   assign timeout    = timeout_q;
   assign err        = err_q;
   assign score0     = score_q[0];
   assign score1     = score_q[1];
   assign score2     = score_q[2];
   assign score3     = score_q[3];

endmodule

// File: tb/tb_answer_record.sv
// Directed bench for answer_record: buzz, judgement, timeout, saturation, error,
// simultaneous ok/ng, reset in CLEAR and clr_score priority.
module tb_answer_record;

   localparam int unsigned ANSWER_TIME = 10;
   localparam int unsigned SCORE_W     = 4;
   localparam int unsigned TW          = $clog2(ANSWER_TIME + 1);

   logic               clk_count = 1'b0;
   logic               rst = 1'b1;
   logic               en_s0 = 1'b0, en_s1 = 1'b0, en_s2 = 1'b0, en_s3 = 1'b0;
   logic               tick = 1'b0, ok = 1'b0, ng = 1'b0, clr_score = 1'b0;
   logic               count, zd_r, winner_vld, timeout, err;
   logic [1:0]         winner;
   logic [TW-1:0]      timer;
   logic [SCORE_W-1:0] score0, score1, score2, score3;

   int n_cmp = 0;
   int n_err = 0;

   answer_record #(.ANSWER_TIME(ANSWER_TIME), .SCORE_W(SCORE_W)) dut (
      .clk_count (clk_count),
      .rst       (rst),
      .en_s0     (en_s0),
      .en_s1     (en_s1),
      .en_s2     (en_s2),
      .en_s3     (en_s3),
      .tick      (tick),
      .ok        (ok),
      .ng        (ng),
      .clr_score (clr_score),
      .count     (count),
      .zd_r      (zd_r),
      .winner    (winner),
      .winner_vld(winner_vld),
      .timer     (timer),
      .score0    (score0),
      .score1    (score1),
      .score2    (score2),
      .score3    (score3),
      .timeout   (timeout),
      .err       (err)
   );

   always #5 clk_count = ~clk_count;

   task automatic step();
      @(posedge clk_count);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One full question for player p, judged ok (good=1) or ng, ending back in IDLE
   task automatic question(input int p, input bit good);
      case (p)
         0: en_s0 = 1'b1;
         1: en_s1 = 1'b1;
         2: en_s2 = 1'b1;
         default: en_s3 = 1'b1;
      endcase
      step();
      {en_s3, en_s2, en_s1, en_s0} = 4'b0000;
      if (good) ok = 1'b1; else ng = 1'b1;
      step();
      ok = 1'b0;
      ng = 1'b0;
      step();
   endtask

   initial begin
      step();
      step();
      rst = 1'b0;
      chk("rst_count", count, 0);
      chk("rst_zd_r", zd_r, 0);
      chk("rst_winner", winner, 0);
      chk("rst_vld", winner_vld, 0);
      chk("rst_timer", timer, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_err", err, 0);
      chk("rst_scores", {score3, score2, score1, score0}, 0);

      // basic buzz by player 2, judged correct
      en_s2 = 1'b1;
      step();
      chk("t1_count", count, 1);
      chk("t1_winner", winner, 2);
      chk("t1_vld", winner_vld, 1);
      chk("t1_timer", timer, 10);
      step();
      chk("t1_ans_zd_r", zd_r, 0);
      ok = 1'b1;
      step();
      ok = 1'b0;
      chk("t1_score2", score2, 1);
      chk("t1_zd_r", zd_r, 1);
      chk("t1_count_clr", count, 1);
      step();
      chk("t1_zd_r_hold", zd_r, 1);
      en_s2 = 1'b0;
      step();
      chk("t1_idle_count", count, 0);
      chk("t1_idle_zd_r", zd_r, 0);
      chk("t1_idle_vld", winner_vld, 0);
      chk("t1_idle_timer", timer, 0);
      chk("t1_others", {score3, score1, score0}, 0);

      // player 0 lets the window expire
      en_s0 = 1'b1;
      step();
      en_s0 = 1'b0;
      chk("t2_winner", winner, 0);
      chk("t2_timer_load", timer, 10);
      for (int i = 1; i <= 9; i++) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
         chk("t2_timer", timer, 10 - i);
         chk("t2_no_timeout", timeout, 0);
         step();
      end
      tick = 1'b1;
      step();
      tick = 1'b0;
      chk("t2_timeout", timeout, 1);
      chk("t2_timer_zero", timer, 0);
      chk("t2_zd_r", zd_r, 1);
      chk("t2_score0_floor", score0, 0);
      step();
      chk("t2_timeout_pulse", timeout, 0);
      chk("t2_idle", count, 0);

      // saturation at top and bottom
      for (int i = 0; i < 15; i++) question(1, 1'b1);
      chk("t3_score1_15", score1, 15);
      question(1, 1'b1);
      chk("t3_score1_sat", score1, 15);
      question(3, 1'b0);
      chk("t3_score3_floor", score3, 0);

      // two buzzers at once
      en_s0 = 1'b1;
      en_s1 = 1'b1;
      step();
      chk("t4_err", err, 1);
      chk("t4_zd_r", zd_r, 1);
      chk("t4_count", count, 1);
      chk("t4_vld", winner_vld, 0);
      step();
      chk("t4_err_pulse", err, 0);
      chk("t4_zd_r_hold", zd_r, 1);
      en_s0 = 1'b0;
      en_s1 = 1'b0;
      step();
      chk("t4_idle_zd_r", zd_r, 0);
      chk("t4_idle_count", count, 0);
      chk("t4_scores", {score3, score2, score1, score0}, {4'd0, 4'd1, 4'd15, 4'd0});

      // ok and ng together with a tick: nothing happens
      en_s3 = 1'b1;
      step();
      en_s3 = 1'b0;
      ok = 1'b1;
      ng = 1'b1;
      tick = 1'b1;
      step();
      ok = 1'b0;
      ng = 1'b0;
      tick = 1'b0;
      chk("t5_timer", timer, 10);
      chk("t5_zd_r", zd_r, 0);
      chk("t5_count", count, 1);
      chk("t5_score3", score3, 0);
      ok = 1'b1;
      step();
      ok = 1'b0;
      chk("t5_score3_inc", score3, 1);
      chk("t5_zd_r_clr", zd_r, 1);
      step();
      chk("t5_idle", count, 0);

      // reset while in CLEAR
      en_s2 = 1'b1;
      step();
      ok = 1'b1;
      step();
      ok = 1'b0;
      chk("t6_in_clear", zd_r, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      en_s2 = 1'b0;
      chk("t6_count", count, 0);
      chk("t6_zd_r", zd_r, 0);
      chk("t6_vld", winner_vld, 0);
      chk("t6_winner", winner, 0);
      chk("t6_timer", timer, 0);
      chk("t6_scores", {score3, score2, score1, score0}, 0);

      // clr_score overrides a coincident increment
      question(1, 1'b1);
      chk("t7_score1", score1, 1);
      en_s0 = 1'b1;
      step();
      en_s0 = 1'b0;
      ok = 1'b1;
      clr_score = 1'b1;
      step();
      ok = 1'b0;
      clr_score = 1'b0;
      chk("t7_score0", score0, 0);
      chk("t7_score1_clr", score1, 0);
      chk("t7_zd_r", zd_r, 1);
      step();
      chk("t7_idle", count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/answer_record.md
# answer_record

Answer-phase controller on the far side of the four-way buzzer detector. It consumes the latched winner flags (en_s0..en_s3), runs a per-question answer countdown and applies the host's correct/wrong judgement to four saturating scores. It drives count high to lock out new buzzes while a question is live, then pulses zd_r to release the winner's latch.

## Interface
- ANSWER_TIME, 10: answer window in tick strobes; legal range 1..255.
- SCORE_W, 4: score width; scores saturate at 2^SCORE_W-1 and at 0.
- TW, derived: timer width, the number of bits needed to hold ANSWER_TIME.

Ports:
- clk_count  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- en_s0..en_s3  in  1 each  latched buzz winner flags from the detector.
- tick  in  1  one-cycle timebase strobe, e.g. 1 Hz.
- ok  in  1  host judges the answer correct (one-cycle pulse).
- ng  in  1  host judges the answer wrong (one-cycle pulse).
- clr_score  in  1  zero all scores.
- count  out  1  answer phase active; the detector accepts buzzes only while count is 0.
- zd_r  out  1  release request to the detector.
- winner  out  2  index of the player currently answering.
- winner_vld  out  1  winner is valid.
- timer  out  TW  remaining answer ticks.
- score0..score3  out  SCORE_W each  player scores.
- timeout  out  1  one-cycle pulse when the answer window expires.
- err  out  1  one-cycle pulse when more than one en_sN is set.

## Operation
- All outputs are registered.
- Reset values: count=0, zd_r=0, winner=0, winner_vld=0, timer=0, timeout=0, err=0, scores=0, state IDLE.
- rst applied in any state returns the block to IDLE with the reset values.

State IDLE (count=0, zd_r=0, winner_vld=0):
- Exactly one en_sN=1: latch winner=N, set winner_vld=1 and count=1, load timer=ANSWER_TIME, go to ANSWER.
- Two or more en_sN set: pulse err, go to CLEAR.
- All en_sN=0: stay in IDLE.

State ANSWER (count=1), conditions in priority order:
- ok=1 and ng=1 together: no action this cycle.
- ok=1: score[winner] +1, saturating; go to CLEAR.
- ng=1: score[winner] -1, saturating at 0; go to CLEAR.
- tick=1 with timer>1: timer -1.
- tick=1 with timer==1: timer=0, pulse timeout, score[winner] -1 saturating at 0, go to CLEAR.

State CLEAR (count=1, zd_r=1):
- Hold zd_r until all en_sN are sampled 0.
- On that sample, the next edge gives zd_r=0, count=0, winner_vld=0, timer=0 and state IDLE.

clr_score:
- Zeroes all four scores in any state.
- Overrides a score update in the same cycle.
- Has no effect on the FSM.

## Timing
- Edge k samples a single en_sN=1 in IDLE. After edge k: count=1, winner and winner_vld valid, timer=ANSWER_TIME.
- The detector must see count=1 no later than the cycle after its own latch. The one extra cycle of buzz acceptance is tolerated because the detector holds the first winner.
- An ok or ng at edge j updates the score and enters CLEAR with zd_r=1 after edge j.
- The detector clears its flag on the first edge that samples zd_r=1. The flags are therefore seen at 0 at edge j+2 at the earliest, and IDLE is reached after edge j+2.
- The minimum question cycle, from buzz to IDLE, is 4 clocks.
- timer decrements only on tick; ok and ng are honoured on any cycle.
- A tick arriving in the same cycle as ok or ng is ignored.
- timeout and err are exactly one cycle wide.
- Buzzes are blocked throughout CLEAR; count falls in the same cycle as zd_r.

## Test plan
- Reset, then en_s2=1 for 1 cycle -> count=1, winner=2, timer=10 next cycle; ok pulse -> score2=1, zd_r=1 until en_s2=0, then count=0 with all other scores at 0.
- Winner 0 with 10 ticks and no judgement -> timer steps 10..1, then the 10th tick gives timeout=1, score0 stays 0 (floor), CLEAR then IDLE.
- score1=15 with SCORE_W=4, winner 1 and ok -> score1 stays 15. score3=0 with ng -> stays 0.
- en_s0=en_s1=1 in IDLE -> err pulse, zd_r=1 until both are low, scores unchanged.
- ok=ng=1 in ANSWER together with a tick -> no state, timer or score change; a later ok gives +1.
- rst asserted during CLEAR, and separately clr_score coincident with ok -> IDLE with reset values; all scores 0 with no increment.
